// File: rtl/mips_cpu.sv
// rtl/mips_cpu.sv - five-stage pipelined MIPS-subset CPU
// Purpose: F/D/E/M/W pipeline with a branch delay slot, branch/jump resolution
//   in D, full forwarding and load-use/branch interlocks.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   i_inst_addr / i_inst_rdata - F-stage PC and the instruction at that PC
//   m_data_addr / m_data_rdata - M-stage byte address and aligned read word
//   m_data_wdata / m_data_byteen - lane-replicated store data and byte enables
//   m_inst_addr                - PC of the M-stage instruction
//   w_grf_we/addr/wdata        - W-stage register-write triple
//   w_inst_addr                - PC of the W-stage instruction
module mips_cpu #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] m_data_addr,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_inst_addr,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr
);

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_PASSB} alu_op_e;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Architectural and pipeline state
  logic [31:0] pc_q, pc_d;
  logic [31:0] grf_q [0:31];

  logic [31:0] d_instr_q, d_pc_q;

  logic [31:0] e_pc_q, e_rs_val_q, e_rt_val_q, e_imm_q;
  logic [4:0]  e_rs_q, e_rt_q, e_dst_q;
  alu_op_e     e_alu_q;
  logic        e_b_imm_q, e_link_q, e_we_q, e_load_q, e_store_q;
  logic [1:0]  e_size_q;

  logic [31:0] m_pc_q, m_rt_val_q, m_result_q;
  logic [4:0]  m_rt_q, m_dst_q;
  logic        m_we_q, m_load_q, m_store_q;
  logic [1:0]  m_size_q;

  logic [31:0] w_pc_q, w_value_q;
  logic [4:0]  w_dst_q;
  logic        w_we_q;

  // ---------------------------------------------------------------- decode
  logic [5:0]  d_op, d_funct;
  logic [4:0]  d_rs, d_rt, d_rd, d_shamt;
  logic [15:0] d_imm;
  assign {d_op, d_rs, d_rt, d_rd, d_shamt, d_funct} = d_instr_q;
  assign d_imm = d_instr_q[15:0];

  logic d_rtype, d_addu, d_subu, d_jr, d_ori, d_lui, d_lw, d_lh, d_lb;
  logic d_sw, d_sh, d_sb, d_beq, d_bne, d_bgezal, d_jal, d_load, d_store;
  assign d_rtype  = (d_op == 6'h00) && (d_shamt == 5'd0);
  assign d_addu   = d_rtype && (d_funct == 6'h21);
  assign d_subu   = d_rtype && (d_funct == 6'h23);
  assign d_jr     = d_rtype && (d_funct == 6'h08);
  assign d_ori    = (d_op == 6'h0d);
  assign d_lui    = (d_op == 6'h0f);
  assign d_lw     = (d_op == 6'h23);
  assign d_lh     = (d_op == 6'h21);
  assign d_lb     = (d_op == 6'h20);
  assign d_sw     = (d_op == 6'h2b);
  assign d_sh     = (d_op == 6'h29);
  assign d_sb     = (d_op == 6'h28);
  assign d_beq    = (d_op == 6'h04);
  assign d_bne    = (d_op == 6'h05);
  assign d_bgezal = (d_op == 6'h01) && (d_rt == 5'h11);
  assign d_jal    = (d_op == 6'h03);
  assign d_load   = d_lw | d_lh | d_lb;
  assign d_store  = d_sw | d_sh | d_sb;

  logic        d_we, d_use_rs, d_use_rt, d_b_imm, d_link;
  logic [4:0]  d_dst;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_size;
  alu_op_e     d_alu;
  logic [31:0] d_imm32;

  always_comb begin
    d_link    = d_jal | d_bgezal;
    d_we      = d_addu | d_subu | d_ori | d_lui | d_load | d_link;
    d_dst     = d_rt;
    if (d_addu | d_subu) d_dst = d_rd;
    if (d_link)          d_dst = 5'd31;
    d_use_rs  = d_addu | d_subu | d_jr | d_ori | d_load | d_store |
                d_beq | d_bne | d_bgezal;
    d_use_rt  = d_addu | d_subu | d_store | d_beq | d_bne;
    d_tuse_rs = (d_jr | d_beq | d_bne | d_bgezal) ? 2'd0 : 2'd1;
    d_tuse_rt = (d_beq | d_bne) ? 2'd0 : (d_store ? 2'd2 : 2'd1);
    d_alu     = ALU_ADD;
    if (d_subu) d_alu = ALU_SUB;
    if (d_ori)  d_alu = ALU_OR;
    if (d_lui)  d_alu = ALU_PASSB;
    d_b_imm   = d_ori | d_lui | d_load | d_store;
    d_imm32   = {{16{d_imm[15]}}, d_imm};
    if (d_ori) d_imm32 = {16'h0000, d_imm};
    if (d_lui) d_imm32 = {d_imm, 16'h0000};
    d_size    = SZ_W;
    if (d_lh | d_sh) d_size = SZ_H;
    if (d_lb | d_sb) d_size = SZ_B;
  end

  // ------------------------------------------------------ hazard / stall
  // Remaining stages until each producer's value exists.
  logic [1:0] e_tnew, m_tnew;
  assign e_tnew = e_link_q ? 2'd0 : (e_load_q ? 2'd2 : 2'd1);
  assign m_tnew = {1'b0, m_load_q};

  function automatic logic hazard(input logic [4:0] r, input logic use_r,
                                  input logic [1:0] tuse);
    hazard = use_r && (r != 5'd0) &&
             ((e_we_q && (e_dst_q == r) && (e_tnew > tuse)) ||
              (m_we_q && (m_dst_q == r) && (m_tnew > tuse)));
  endfunction

  logic stall;
  assign stall = hazard(d_rs, d_use_rs, d_tuse_rs) ||
                 hazard(d_rt, d_use_rt, d_tuse_rt);

  // D-stage operand read: link value from E, ready results from M, then the
  // GRF with W write-through.
  function automatic logic [31:0] read_d(input logic [4:0] r);
    if (r == 5'd0)                                       read_d = 32'h0;
    else if (e_we_q && e_link_q && (e_dst_q == r))       read_d = e_pc_q + 32'd8;
    else if (m_we_q && !m_load_q && (m_dst_q == r))      read_d = m_result_q;
    else if (w_we_q && (w_dst_q == r))                   read_d = w_value_q;
    else                                                 read_d = grf_q[r];
  endfunction

  logic [31:0] d_rs_val, d_rt_val, d_pc4, d_br_target;
  logic        d_taken;
  assign d_rs_val    = read_d(d_rs);
  assign d_rt_val    = read_d(d_rt);
  assign d_pc4       = d_pc_q + 32'd4;
  assign d_br_target = d_pc4 + {{14{d_imm[15]}}, d_imm, 2'b00};
  assign d_taken     = (d_beq && (d_rs_val == d_rt_val)) ||
                       (d_bne && (d_rs_val != d_rt_val)) ||
                       (d_bgezal && !d_rs_val[31]);

  // Redirects take effect on the fetch after the delay slot, which is
  // already in F while the branch sits in D.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (stall)        pc_d = pc_q;
    else if (d_jr)    pc_d = d_rs_val;
    else if (d_jal)   pc_d = {d_pc4[31:28], d_instr_q[25:0], 2'b00};
    else if (d_taken) pc_d = d_br_target;
  end

  // ------------------------------------------------------------- execute
  // A matching load in M is not ready; only a store's rt can reach E that
  // way, and it is repaired from W in M.
  function automatic logic [31:0] fwd_e(input logic [4:0] r, input logic [31:0] v);
    if (r == 5'd0)                                       fwd_e = v;
    else if (m_we_q && !m_load_q && (m_dst_q == r))      fwd_e = m_result_q;
    else if (w_we_q && (w_dst_q == r))                   fwd_e = w_value_q;
    else                                                 fwd_e = v;
  endfunction

  logic [31:0] e_rs_fwd, e_rt_fwd, e_b, e_result;
  assign e_rs_fwd = fwd_e(e_rs_q, e_rs_val_q);
  assign e_rt_fwd = fwd_e(e_rt_q, e_rt_val_q);
  assign e_b      = e_b_imm_q ? e_imm_q : e_rt_fwd;

  always_comb begin
    unique case (e_alu_q)
      ALU_SUB:   e_result = e_rs_fwd - e_b;
      ALU_OR:    e_result = e_rs_fwd | e_b;
      ALU_PASSB: e_result = e_b;
      default:   e_result = e_rs_fwd + e_b;
    endcase
    if (e_link_q) e_result = e_pc_q + 32'd8;
  end

  // -------------------------------------------------------------- memory
  logic [31:0] m_rt_fwd, m_ld_val;
  logic [1:0]  m_off;
  logic [7:0]  m_ld_byte;
  logic [15:0] m_ld_half;
  assign m_off    = m_result_q[1:0];
  assign m_rt_fwd = (w_we_q && (m_rt_q != 5'd0) && (w_dst_q == m_rt_q)) ?
                    w_value_q : m_rt_val_q;

  always_comb begin
    m_data_byteen = 4'b0000;
    m_data_wdata  = 32'h0;
    if (m_store_q) begin
      case (m_size_q)
        SZ_W: begin
          m_data_byteen = 4'b1111;
          m_data_wdata  = m_rt_fwd;
        end
        SZ_H: begin
          m_data_byteen = m_off[1] ? 4'b1100 : 4'b0011;
          m_data_wdata  = {2{m_rt_fwd[15:0]}};
        end
        default: begin
          m_data_byteen = 4'b0001 << m_off;
          m_data_wdata  = {4{m_rt_fwd[7:0]}};
        end
      endcase
    end
  end

  always_comb begin
    case (m_off)
      2'd0:    m_ld_byte = m_data_rdata[7:0];
      2'd1:    m_ld_byte = m_data_rdata[15:8];
      2'd2:    m_ld_byte = m_data_rdata[23:16];
      default: m_ld_byte = m_data_rdata[31:24];
    endcase
    m_ld_half = m_off[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    case (m_size_q)
      SZ_B:    m_ld_val = {{24{m_ld_byte[7]}}, m_ld_byte};
      SZ_H:    m_ld_val = {{16{m_ld_half[15]}}, m_ld_half};
      default: m_ld_val = m_data_rdata;
    endcase
  end

  // ----------------------------------------------------- pipeline registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= PC_RESET;
      d_instr_q  <= '0;  d_pc_q     <= '0;
      e_pc_q     <= '0;  e_rs_val_q <= '0;  e_rt_val_q <= '0;  e_imm_q <= '0;
      e_rs_q     <= '0;  e_rt_q     <= '0;  e_dst_q    <= '0;  e_alu_q <= ALU_ADD;
      e_b_imm_q  <= 1'b0; e_link_q  <= 1'b0; e_we_q     <= 1'b0;
      e_load_q   <= 1'b0; e_store_q <= 1'b0; e_size_q   <= '0;
      m_pc_q     <= '0;  m_rt_val_q <= '0;  m_result_q <= '0;
      m_rt_q     <= '0;  m_dst_q    <= '0;  m_we_q     <= 1'b0;
      m_load_q   <= 1'b0; m_store_q <= 1'b0; m_size_q   <= '0;
      w_pc_q     <= '0;  w_value_q  <= '0;  w_dst_q    <= '0;  w_we_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (!stall) begin
        d_instr_q <= i_inst_rdata;
        d_pc_q    <= pc_q;
      end
      if (stall) begin
        // Bubble into E while D waits for its operands.
        e_pc_q    <= '0;  e_rs_val_q <= '0;  e_rt_val_q <= '0;  e_imm_q <= '0;
        e_rs_q    <= '0;  e_rt_q     <= '0;  e_dst_q    <= '0;  e_alu_q <= ALU_ADD;
        e_b_imm_q <= 1'b0; e_link_q  <= 1'b0; e_we_q     <= 1'b0;
        e_load_q  <= 1'b0; e_store_q <= 1'b0; e_size_q   <= '0;
      end else begin
        e_pc_q    <= d_pc_q;  e_rs_val_q <= d_rs_val; e_rt_val_q <= d_rt_val;
        e_imm_q   <= d_imm32; e_rs_q     <= d_rs;     e_rt_q     <= d_rt;
        e_dst_q   <= d_dst;   e_alu_q    <= d_alu;    e_b_imm_q  <= d_b_imm;
        e_link_q  <= d_link;  e_we_q     <= d_we;     e_load_q   <= d_load;
        e_store_q <= d_store; e_size_q   <= d_size;
      end
      m_pc_q     <= e_pc_q;   m_rt_val_q <= e_rt_fwd; m_result_q <= e_result;
      m_rt_q     <= e_rt_q;   m_dst_q    <= e_dst_q;  m_we_q     <= e_we_q;
      m_load_q   <= e_load_q; m_store_q  <= e_store_q; m_size_q  <= e_size_q;
      w_pc_q     <= m_pc_q;
      w_value_q  <= m_load_q ? m_ld_val : m_result_q;
      w_dst_q    <= m_dst_q;
      w_we_q     <= m_we_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) grf_q[i] <= '0;
    end else if (w_we_q && (w_dst_q != 5'd0)) begin
      grf_q[w_dst_q] <= w_value_q;
    end
  end

  assign i_inst_addr = pc_q;
  assign m_data_addr = m_result_q;
  assign m_inst_addr = m_pc_q;
  assign w_grf_we    = w_we_q;
  assign w_grf_addr  = w_dst_q;
  assign w_grf_wdata = w_value_q;
  assign w_inst_addr = w_pc_q;

endmodule

// File: tb/tb_mips_cpu.sv
// tb/tb_mips_cpu.sv - scoreboard bench for mips_cpu
module tb_mips_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_inst_addr, i_inst_rdata;
  logic [31:0] m_data_addr, m_data_rdata, m_data_wdata, m_inst_addr;
  logic [3:0]  m_data_byteen;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata, w_inst_addr;

  always #5 clk = ~clk;

  mips_cpu #(.PC_RESET(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata),
    .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_inst_addr(m_inst_addr),
    .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
    .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr)
  );

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  logic [31:0] ioff;
  assign ioff         = i_inst_addr - 32'h0000_3000;
  assign i_inst_rdata = (ioff < 32'h100) ? imem[ioff[7:2]] : 32'h0;
  assign m_data_rdata = dmem[m_data_addr[7:2]];

  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (m_data_byteen[b]) dmem[m_data_addr[7:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];

  typedef struct { logic [31:0] pc; logic [4:0] rg; logic [31:0] data; } wexp_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } sexp_t;
  wexp_t w_q[$];
  sexp_t s_q[$];

  int tests = 0, fails = 0;
  int cyc = 0, first_w_cyc = -1, lw_cyc = -1, addu_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic put(input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] o;
    o = pc - 32'h0000_3000;
    imem[o[7:2]] = ins;
  endtask
  task automatic push_w(input logic [31:0] pc, input logic [4:0] rg, input logic [31:0] d);
    wexp_t e;
    e.pc = pc; e.rg = rg; e.data = d;
    w_q.push_back(e);
  endtask
  task automatic push_s(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    sexp_t e;
    e.addr = a; e.be = be; e.wd = wd;
    s_q.push_back(e);
  endtask

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Monitor: retire-order W trace and store events against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (w_grf_we) begin
        if (first_w_cyc < 0) first_w_cyc = cyc;
        if (w_inst_addr == 32'h302c) lw_cyc = cyc;
        if (w_inst_addr == 32'h3030) addu_cyc = cyc;
        if (w_q.size() == 0) begin
          check("unexpected_w_write_pc", w_inst_addr, 32'hffff_ffff);
        end else begin
          wexp_t e;
          e = w_q.pop_front();
          check("w_pc", w_inst_addr, e.pc);
          check("w_reg", {27'd0, w_grf_addr}, {27'd0, e.rg});
          check("w_data", w_grf_wdata, e.data);
        end
      end
      if (m_data_byteen != 4'b0000) begin
        if (s_q.size() == 0) begin
          check("unexpected_store_addr", m_data_addr, 32'hffff_ffff);
        end else begin
          sexp_t s;
          s = s_q.pop_front();
          check("st_addr", m_data_addr, s.addr);
          check("st_byteen", {28'd0, m_data_byteen}, {28'd0, s.be});
          check("st_wdata", m_data_wdata, s.wd);
        end
      end
    end
  end

  task automatic check_reset_state();
    check("rst_pc", i_inst_addr, 32'h0000_3000);
    check("rst_grf_we", {31'd0, w_grf_we}, 32'd0);
    check("rst_byteen", {28'd0, m_data_byteen}, 32'd0);
    check("rst_w_pc", w_inst_addr, 32'd0);
    check("rst_m_pc", m_inst_addr, 32'd0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
  endtask

  task automatic load_prog_a();
    put(32'h3000, enc_i(6'h0d, 0, 8, 16'h0001));  push_w(32'h3000, 8, 32'h1);
    put(32'h3004, enc_i(6'h0d, 0, 1, 16'h5678));  push_w(32'h3004, 1, 32'h5678);
    put(32'h3008, enc_i(6'h0f, 0, 2, 16'h1234));  push_w(32'h3008, 2, 32'h1234_0000);
    put(32'h300c, enc_r(2, 1, 3, 6'h21));         push_w(32'h300c, 3, 32'h1234_5678);
    put(32'h3010, enc_i(6'h2b, 0, 3, 16'h0000));  push_s(32'h0, 4'b1111, 32'h1234_5678);
    put(32'h3014, enc_i(6'h28, 0, 3, 16'h0001));  push_s(32'h1, 4'b0010, 32'h7878_7878);
    put(32'h3018, enc_i(6'h20, 0, 4, 16'h0001));  push_w(32'h3018, 4, 32'h0000_0078);
    put(32'h301c, enc_i(6'h0d, 0, 6, 16'hff80));  push_w(32'h301c, 6, 32'h0000_ff80);
    put(32'h3020, enc_i(6'h29, 0, 6, 16'h0002));  push_s(32'h2, 4'b1100, 32'hff80_ff80);
    put(32'h3024, enc_i(6'h21, 0, 5, 16'h0002));  push_w(32'h3024, 5, 32'hffff_ff80);
    put(32'h3028, enc_i(6'h2b, 0, 8, 16'h0004));  push_s(32'h4, 4'b1111, 32'h0000_0001);
    put(32'h302c, enc_i(6'h23, 0, 2, 16'h0004));  push_w(32'h302c, 2, 32'h1);
    put(32'h3030, enc_r(2, 2, 3, 6'h21));         push_w(32'h3030, 3, 32'h2);
    put(32'h3034, enc_r(0, 8, 16, 6'h23));        push_w(32'h3034, 16, 32'hffff_ffff);
    put(32'h3038, enc_i(6'h01, 16, 5'h11, 16'h3)); push_w(32'h3038, 31, 32'h3040);
    put(32'h303c, enc_i(6'h0d, 0, 9, 16'h0009));  push_w(32'h303c, 9, 32'h9);
    put(32'h3040, enc_i(6'h01, 8, 5'h11, 16'h3));  push_w(32'h3040, 31, 32'h3048);
    put(32'h3044, enc_r(31, 0, 15, 6'h21));       push_w(32'h3044, 15, 32'h3048);
    put(32'h3048, enc_i(6'h0d, 0, 10, 16'h0bad));
    put(32'h304c, enc_i(6'h0d, 0, 10, 16'h0bad));
    put(32'h3050, enc_i(6'h0d, 0, 11, 16'h0011));  push_w(32'h3050, 11, 32'h11);
    put(32'h3054, enc_i(6'h04, 0, 0, 16'hffff));
  endtask

  task automatic load_prog_b();
    put(32'h3000, enc_i(6'h0d, 0, 1, 16'h0001));  push_w(32'h3000, 1, 32'h1);
    put(32'h3004, enc_i(6'h0d, 0, 2, 16'h0002));  push_w(32'h3004, 2, 32'h2);
    put(32'h3008, enc_r(8, 9, 6, 6'h21));         push_w(32'h3008, 6, 32'h0);
    put(32'h300c, enc_i(6'h0d, 0, 0, 16'h0007));  push_w(32'h300c, 0, 32'h7);
    put(32'h3010, {6'h03, 26'h0000c0c});          push_w(32'h3010, 31, 32'h3018);
    put(32'h3014, enc_i(6'h0d, 0, 3, 16'h0003));  push_w(32'h3014, 3, 32'h3);
    put(32'h3018, enc_i(6'h0d, 0, 4, 16'h0004));
    put(32'h301c, enc_i(6'h04, 0, 0, 16'hffff));
    put(32'h3030, enc_r(31, 0, 0, 6'h08));
    put(32'h3034, enc_i(6'h0d, 0, 5, 16'h0005));  push_w(32'h3034, 5, 32'h5);
    push_w(32'h3018, 4, 32'h4);
  endtask

  initial begin
    reset = 1'b1;
    clear_mem();
    load_prog_a();
    repeat (2) @(negedge clk);
    #2 check_reset_state();
    @(negedge clk) reset = 1'b0;
    repeat (80) @(negedge clk);
    check("first_w_latency", first_w_cyc, 32'd4);
    check("load_use_gap", addu_cyc - lw_cyc, 32'd2);
    check("a_w_queue_left", w_q.size(), 32'd0);
    check("a_st_queue_left", s_q.size(), 32'd0);

    // Reset while the first program is spinning in its loop.
    #2 reset = 1'b1;
    #1 check_reset_state();
    w_q.delete();
    s_q.delete();
    clear_mem();
    load_prog_b();
    @(negedge clk) reset = 1'b0;
    repeat (60) @(negedge clk);
    check("b_w_queue_left", w_q.size(), 32'd0);
    check("b_st_queue_left", s_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_cpu.md
Name: mips_cpu

Overview:
- Five-stage pipelined MIPS-subset CPU: F, D, E, M, W.
- Has a branch delay slot, full forwarding and load-use/branch stalls.
- Instruction memory and data memory are external. Instruction fetch is combinational by address. Data memory reads combinationally and is written by the memory on posedge clk under byte enables.
- Exposes the W-stage register-write triple for trace checking.

Parameters:
- PC_RESET, 32'h0000_3000, fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- i_inst_addr  out  32  F-stage PC.
- i_inst_rdata  in  32  instruction at i_inst_addr, same cycle.
- m_data_addr  out  32  M-stage byte address (base + sign-extended imm16).
- m_data_rdata  in  32  word at m_data_addr aligned down, same cycle.
- m_data_wdata  out  32  M-stage store data, lane-replicated.
- m_data_byteen  out  4  byte write enables; 0 = no write.
- m_inst_addr  out  32  PC of the M-stage instruction.
- w_grf_we  out  1  W-stage register write enable.
- w_grf_addr  out  5  W-stage destination register.
- w_grf_wdata  out  32  W-stage write data.
- w_inst_addr  out  32  PC of the W-stage instruction.

Behaviour:
- ISA:
  - R-type: addu (funct 21), subu (23), jr (08), nop/sll (all-zero word treated as nop).
  - I-type: ori (0d, zero-ext), lui (0f), lw (23), lh (21), lb (20), sw (2b), sh (29), sb (28), beq (04), bne (05).
  - Other: bgezal (op 01, rt=11), jal (03).
  - Any other encoding executes as nop.
- Arithmetic: 32-bit wrap, no overflow traps. lui = imm<<16.
- Reset:
  - PC=PC_RESET.
  - All pipeline registers hold nop with PC field 0.
  - All 32 GRF registers = 0.
  - m_data_byteen=0, w_grf_we=0.
- GRF:
  - $0 always reads 0; writes to $0 are discarded.
  - Write-through: a W-stage write is visible to a D-stage read in the same cycle.
- Control flow is resolved in D:
  - beq/bne target = PC_D+4+(sext(imm)<<2).
  - bgezal is taken when rs ≥ 0 (signed).
  - jal target = {PC_D+4[31:28], imm26, 2'b00}.
  - jr target = rs.
  - The instruction after a branch/jump (delay slot) always executes; no annulment.
- Link: jal and bgezal write $31 = PC+8. bgezal writes $31 whether or not the branch is taken.
- Loads:
  - Byte offset = addr[1:0].
  - lb sign-extends rdata byte[off].
  - lh sign-extends halfword[off[1]].
  - lw takes the full word.
- Stores:
  - sw: byteen 1111, wdata=rt.
  - sh: byteen 0011 (off=0) or 1100 (off=2), wdata={2{rt[15:0]}}.
  - sb: byteen = 1<<off, wdata={4{rt[7:0]}}.
  - Unaligned lw/sw/lh/sh behaviour is unspecified.
- Result ready time (Tnew, stages until value is available for forwarding):
  - Link instructions: value ready in E.
  - ALU/lui: ready at M.
  - Loads: ready at W.
- Use time (Tuse):
  - branch/jr operands: 0.
  - ALU rs/rt and address base: 1.
  - store rt: 2.
- Stall:
  - When a nonzero source register matches an E or M destination whose remaining Tnew > Tuse, stall.
  - On stall, freeze PC and F/D, and load a bubble (nop, we=0) into D/E.
- Forwarding:
  - To D (branch compare/jr) from E (link) and M; to E operands from M and W; to M store data from W.
  - Priority: youngest producer first, then GRF.
  - Never forward for register 0.
- W outputs:
  - w_grf_we=1 for any register-writing instruction, even if the destination is 0.
  - For an instruction in W: w_inst_addr = its PC; w_grf_addr = destination (rd for R-type, rt for I-type, 31 for link).
- Reset asserted mid-operation clears everything immediately; the first fetch after release is from PC_RESET.

Test Plan:
- Reset then `ori $8,$0,1` at 0x3000 → W trace shows PC 00003000, reg 8, data 00000001, four cycles after the first fetch.
- `ori $1,$0,0x5678`; `lui $2,0x1234`; `addu $3,$2,$1`; `sw $3,0($0)` (back-to-back, exercises forwarding) → $3=12345678; store with byteen 1111, addr 0, wdata 12345678.
- `sb $3,1($0)` with $3=12345678 → byteen 0010, wdata 78787878. Then `lb $4,1($0)` returns 00000078. `lh $5,2($0)` after `sh $6,2($0)` with $6=0000ff80 returns ffffff80.
- Load-use: `lw $2,0($0)`; `addu $3,$2,$2` with mem[0]=1 → exactly one bubble; $3=00000002.
- `subu $16,$0,1`; `bgezal $16,T` → not taken; the delay slot executes; $31=PC+8. `bgezal $8,T` with $8=1 → taken; the delay slot executes; `addu $15,$31,$0` in the delay slot gets the forwarded PC+8.
- `jal F` at 0x3010, then `jr $31` in F → $31=00003018; execution returns to 0x3018. Delay slots of both jal and jr execute.
